// File: rtl/wbs_arbiter.sv
// Wishbone single-master to NUM_SLAVES address decoder/bridge.
// It latches one request, forwards it with a window-relative address, and returns ack/data or an error.
module wbs_arbiter #(
  parameter int                        NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_ADDR = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_HIGH = {32'h0003_ffff, 32'h0002_ffff, 32'h0001_ffff, 32'h0000_ffff},
  parameter int                        TIMEOUT    = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wbm_cyc_i,
  input  logic                        wbm_stb_i,
  input  logic                        wbm_we_i,
  input  logic [3:0]                  wbm_sel_i,
  input  logic [31:0]                 wbm_adr_i,
  input  logic [31:0]                 wbm_dat_i,
  output logic [31:0]                 wbm_dat_o,
  output logic                        wbm_ack_o,
  output logic                        wbm_err_o,
  output logic [NUM_SLAVES-1:0]       wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]       wbs_stb_o,
  output logic                        wbs_we_o,
  output logic [3:0]                  wbs_sel_o,
  output logic [31:0]                 wbs_adr_o,
  output logic [31:0]                 wbs_dat_o,
  input  logic [32*NUM_SLAVES-1:0]    wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]       wbs_ack_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } req_t;

  state_e                 state_q;
  req_t                   req_q;
  logic [NUM_SLAVES-1:0]  cyc_q;
  logic [31:0]            adr_q;
  logic [31:0]            rdat_q;
  logic                   ack_q;
  logic                   err_q;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [NUM_SLAVES-1:0]  win_hit;
  logic                   dec_hit;
  logic [NUM_SLAVES-1:0]  dec_oh;
  logic [31:0]            dec_rel;
  logic                   slv_ack;
  logic [31:0]            slv_rdat;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_win
    assign win_hit[g] = (wbm_adr_i >= SLAVE_ADDR[32*g +: 32]) &&
                        (wbm_adr_i <= SLAVE_HIGH[32*g +: 32]);
  end

  // Scan downwards so the lowest matching window is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_oh  = '0;
    dec_rel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (win_hit[i]) begin
        dec_hit    = 1'b1;
        dec_oh     = '0;
        dec_oh[i]  = 1'b1;
        dec_rel    = wbm_adr_i - SLAVE_ADDR[32*i +: 32];
      end
    end
  end

  // Only the selected slave's ack and data slice are visible.
  always_comb begin
    slv_rdat = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (cyc_q[i]) slv_rdat = slv_rdat | wbs_dat_i[32*i +: 32];
  end

  assign slv_ack = |(wbs_ack_i & cyc_q);
  assign cnt_d   = cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      cyc_q   <= '0;
      adr_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            req_q <= '{we: wbm_we_i, sel: wbm_sel_i, dat: wbm_dat_i};
            if (dec_hit) begin
              cyc_q   <= dec_oh;
              adr_q   <= dec_rel;
              cnt_q   <= '0;
              state_q <= BUSY;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (slv_ack) begin
            cyc_q   <= '0;
            ack_q   <= 1'b1;
            rdat_q  <= slv_rdat;
            state_q <= IDLE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            cyc_q   <= '0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbm_dat_o = rdat_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;
  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = cyc_q;
  assign wbs_we_o  = req_q.we;
  assign wbs_sel_o = req_q.sel;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = req_q.dat;

endmodule

// File: tb/tb_wbs_arbiter.sv
// Randomized bench for wbs_arbiter: 14 slaves with 64 KiB windows at i<<16.
// Expected behaviour comes from window arithmetic and cycle counts relative to the request edge.
module tb_wbs_arbiter;

  localparam int NS = 14;
  localparam int TO = 20;

  function automatic logic [32*NS-1:0] win(input bit top);
    logic [32*NS-1:0] r;
    r = '0;
    for (int i = 0; i < NS; i++)
      r[32*i +: 32] = (32'(i) << 16) | (top ? 32'h0000_ffff : 32'h0);
    return r;
  endfunction

  localparam logic [32*NS-1:0] BASE = win(1'b0);
  localparam logic [32*NS-1:0] TOP  = win(1'b1);

  logic              clk, reset;
  logic              wbm_cyc_i, wbm_stb_i, wbm_we_i;
  logic [3:0]        wbm_sel_i;
  logic [31:0]       wbm_adr_i, wbm_dat_i, wbm_dat_o;
  logic              wbm_ack_o, wbm_err_o;
  logic [NS-1:0]     wbs_cyc_o, wbs_stb_o;
  logic              wbs_we_o;
  logic [3:0]        wbs_sel_o;
  logic [31:0]       wbs_adr_o, wbs_dat_o;
  logic [32*NS-1:0]  wbs_dat_i;
  logic [NS-1:0]     wbs_ack_i;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_rdat = '0;

  wbs_arbiter #(.NUM_SLAVES(NS), .SLAVE_ADDR(BASE), .SLAVE_HIGH(TOP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_sel_i(wbm_sel_i), .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic rnd_slave_data();
    for (int i = 0; i < NS; i++) wbs_dat_i[32*i +: 32] = $urandom;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".cyc"}, 32'(wbs_cyc_o), 32'h0);
    chk({tag, ".stb"}, 32'(wbs_stb_o), 32'h0);
    chk({tag, ".ack"}, 32'(wbm_ack_o), 32'h0);
    chk({tag, ".err"}, 32'(wbm_err_o), 32'h0);
    chk({tag, ".we"},  32'(wbs_we_o),  32'h0);
    chk({tag, ".sel"}, 32'(wbs_sel_o), 32'h0);
    chk({tag, ".adr"}, wbs_adr_o, 32'h0);
    chk({tag, ".wdat"}, wbs_dat_o, 32'h0);
    chk({tag, ".rdat"}, wbm_dat_o, 32'h0);
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      wbs_ack_i = '0;
      @(posedge clk); @(negedge clk);
      chk("idle.ack", 32'(wbm_ack_o), 32'h0);
      chk("idle.err", 32'(wbm_err_o), 32'h0);
      chk("idle.cyc", 32'(wbs_cyc_o), 32'h0);
      chk("idle.rdat", wbm_dat_o, exp_rdat);
    end
  endtask

  // Called and returns at a negedge. lat<0: slave never acks; abort_at>=0: reset at that BUSY cycle.
  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                     input logic [3:0] sel, input int lat, input bit spur,
                     input int abort_at, input logic [31:0] rd);
    bit hit;
    int k;
    logic [31:0] rel;
    logic [NS-1:0] oh;
    hit = (adr >> 16) < NS;
    k   = hit ? int'(adr >> 16) : 0;
    rel = adr & 32'h0000_ffff;
    oh  = hit ? (NS'(1) << k) : '0;

    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    wbm_we_i = we; wbm_sel_i = sel; wbm_adr_i = adr; wbm_dat_i = wd;
    wbs_ack_i = '0;
    @(posedge clk); @(negedge clk);
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    wbm_we_i = ~we; wbm_sel_i = ~sel; wbm_adr_i = $urandom; wbm_dat_i = $urandom;

    chk("req.err", 32'(wbm_err_o), 32'(!hit));
    chk("req.ack", 32'(wbm_ack_o), 32'h0);
    chk("req.cyc", 32'(wbs_cyc_o), 32'(oh));
    chk("req.stb", 32'(wbs_stb_o), 32'(oh));
    chk("req.rdat", wbm_dat_o, exp_rdat);
    if (!hit) return;
    chk("req.adr", wbs_adr_o, rel);
    chk("req.we", 32'(wbs_we_o), 32'(we));
    chk("req.sel", 32'(wbs_sel_o), 32'(sel));
    chk("req.wdat", wbs_dat_o, wd);

    for (int n = 0; n <= TO + 1; n++) begin
      rnd_slave_data();
      wbs_ack_i = '0;
      if (spur)
        for (int j = 0; j < NS; j++)
          if (j != k && $urandom_range(0, 1) == 1) wbs_ack_i[j] = 1'b1;
      if (n == lat) begin
        wbs_ack_i[k] = 1'b1;
        wbs_dat_i[32*k +: 32] = rd;
      end
      if (n == abort_at) reset = 1'b1;
      @(posedge clk); @(negedge clk);
      if (n == abort_at) begin
        reset = 1'b0;
        wbs_ack_i = '0;
        exp_rdat = '0;
        chk_all_zero("abort");
        return;
      end
      if (n == lat) begin
        exp_rdat = rd;
        wbs_ack_i = '0;
        chk("done.ack", 32'(wbm_ack_o), 32'h1);
        chk("done.err", 32'(wbm_err_o), 32'h0);
        chk("done.cyc", 32'(wbs_cyc_o), 32'h0);
        chk("done.stb", 32'(wbs_stb_o), 32'h0);
        chk("done.rdat", wbm_dat_o, exp_rdat);
        return;
      end
      if (n + 1 == TO) begin
        wbs_ack_i = '0;
        chk("tmo.err", 32'(wbm_err_o), 32'h1);
        chk("tmo.ack", 32'(wbm_ack_o), 32'h0);
        chk("tmo.cyc", 32'(wbs_cyc_o), 32'h0);
        chk("tmo.rdat", wbm_dat_o, exp_rdat);
        return;
      end
      chk("busy.cyc", 32'(wbs_cyc_o), 32'(oh));
      chk("busy.ack", 32'(wbm_ack_o), 32'h0);
      chk("busy.err", 32'(wbm_err_o), 32'h0);
      chk("busy.adr", wbs_adr_o, rel);
    end
  endtask

  initial begin
    logic [31:0] a;
    int lat;
    reset = 1'b1;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_we_i = 1'b0;
    wbm_sel_i = '0; wbm_adr_i = '0; wbm_dat_i = '0;
    wbs_dat_i = '0; wbs_ack_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;
    idle(1);

    for (int i = 0; i < NS; i++) begin
      a = (32'(i) << 16) | 32'h0000_dead;
      txn(1'b1, a, 32'hdeadbeef, 4'hf, 1, 1'b0, -1, $urandom);
    end
    for (int i = 0; i < NS; i++) begin
      a = (32'(i) << 16) | 32'h0000_dead;
      txn(1'b0, a, $urandom, 4'hf, 1, 1'b0, -1, 32'hdeadbeef);
    end

    txn(1'b0, 32'h00ff_0000, $urandom, 4'h3, 1, 1'b0, -1, $urandom);
    idle(1);
    txn(1'b0, 32'h000d_ffff, $urandom, 4'h1, 0, 1'b0, -1, $urandom);
    txn(1'b0, 32'h000e_0000, $urandom, 4'h1, 0, 1'b0, -1, $urandom);
    txn(1'b1, 32'h8000_0000, $urandom, 4'h1, 0, 1'b0, -1, $urandom);
    txn(1'b0, 32'h0000_0000, $urandom, 4'h8, 0, 1'b0, -1, $urandom);

    txn(1'b1, 32'h0002_1234, $urandom, 4'h5, -1, 1'b0, -1, $urandom);
    idle(1);
    txn(1'b0, 32'h0002_1234, $urandom, 4'hf, 1, 1'b0, -1, $urandom);

    txn(1'b0, 32'h0005_0040, $urandom, 4'hc, 5, 1'b1, -1, $urandom);

    txn(1'b1, 32'h0003_0010, $urandom, 4'hf, -1, 1'b0, 3, $urandom);
    idle(1);
    txn(1'b0, 32'h0003_0010, $urandom, 4'hf, 2, 1'b0, -1, $urandom);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = (32'($urandom_range(0, NS - 1)) << 16) | 32'($urandom_range(0, 16'hffff));
      lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
      txn(1'($urandom), a, $urandom, 4'($urandom), lat, 1'($urandom_range(0, 1)), -1, $urandom);
      idle(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
